// File: rtl/multicycle_alu.sv
// multicycle_alu: registered EX-stage ALU; mult/div run for a set number of cycles into HI/LO.
// Build option: define MULTICYCLE_ALU_DIV_EN to include the divider (div/divu).
module multicycle_alu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);
    localparam int SW   = $clog2(WIDTH);
    localparam int MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t             state;
    state_t             state_d;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               uns_q;
    logic               is_mul;
    logic               is_div;
    logic               acc;
    logic               go;
    logic               fin;
    logic [SW-1:0]      sa;
    logic [WIDTH-1:0]   sc_res;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] res;

    assign sa     = B[SW-1:0];
    assign is_mul = (ALUOp[3:1] == 3'b100);
    assign busy   = (state == EXEC);

    always_comb begin
        sc_res = '0;
        case (ALUOp)
            4'b0000: sc_res = A + B;
            4'b0001: sc_res = A - B;
            4'b0010: sc_res = A & B;
            4'b0011: sc_res = A | B;
            4'b0100: sc_res = A >> sa;
            4'b0101: sc_res = $signed(A) >>> sa;
            4'b0110: sc_res = A << sa;
            4'b0111: sc_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            default: sc_res = '0;
        endcase
    end

    // Low 2*WIDTH bits of the product of extended operands give both mult and multu.
    assign prod = {{WIDTH{~uns_q & opa[WIDTH-1]}}, opa}
                * {{WIDTH{~uns_q & opb[WIDTH-1]}}, opb};

`ifdef MULTICYCLE_ALU_DIV_EN
    logic             div_q;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] qm;
    logic [WIDTH-1:0] rm;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    assign is_div = (ALUOp[3:1] == 3'b101);

    // Divide magnitudes, then restore signs; most-negative / -1 falls out as LO=A, HI=0.
    always_comb begin
        neg_a = ~uns_q & opa[WIDTH-1];
        neg_b = ~uns_q & opb[WIDTH-1];
        ma    = neg_a ? -opa : opa;
        mb    = neg_b ? -opb : opb;
        qm    = ma / mb;
        rm    = ma % mb;
        quo   = (neg_a ^ neg_b) ? -qm : qm;
        rem   = neg_a ? -rm : rm;
        if (opb == '0) begin
            quo = '1;
            rem = opa;
        end
    end

    assign res = div_q ? {rem, quo} : prod;
`else
    assign is_div = 1'b0;
    assign res    = prod;
`endif

    always_comb begin
        state_d = state;
        acc     = 1'b0;
        go      = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc = 1'b1;
                    if (is_mul || is_div) begin
                        go      = 1'b1;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            uns_q <= 1'b0;
            C     <= '0;
            HI    <= '0;
            LO    <= '0;
            done  <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            done <= (acc & ~go) | fin;
            if (go) begin
                opa   <= A;
                opb   <= B;
                uns_q <= ALUOp[0];
                cnt   <= is_mul ? CW'(MUL_CYCLES - 1) : CW'(DIV_CYCLES - 1);
`ifdef MULTICYCLE_ALU_DIV_EN
                div_q <= is_div;
`endif
            end else if (busy && !fin) begin
                cnt <= cnt - CW'(1);
            end
            if (fin) {HI, LO} <= res;
            if (acc && !go) begin
                if (ALUOp == 4'b1100)      HI <= A;
                else if (ALUOp == 4'b1101) LO <= A;
                else                       C  <= sc_res;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed and random checks of multicycle_alu against an
// arithmetic reference model of C/HI/LO and completion latency.
module tb_multicycle_alu;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   ALUOp;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [31:0] mC;
    logic [31:0] mHI;
    logic [31:0] mLO;

    always #5 clk = ~clk;

    multicycle_alu #(
        .WIDTH     (W),
        .MUL_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .ALUOp(ALUOp),
        .A    (A),
        .B    (B),
        .C    (C),
        .HI   (HI),
        .LO   (LO),
        .busy (busy),
        .done (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: updates model registers, returns extra edges until done.
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        logic [63:0] p;
        int sh;
        int sa_i;
        int sb_i;
        sh   = int'(b[4:0]);
        sa_i = a;
        sb_i = b;
        lat  = 0;
        case (op)
            4'd0: mC = a + b;
            4'd1: mC = a - b;
            4'd2: mC = a & b;
            4'd3: mC = a | b;
            4'd4: mC = a >> sh;
            4'd5: mC = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd6: mC = a << sh;
            4'd7: mC = (sa_i < sb_i) ? 32'd1 : 32'd0;
            4'd8: begin
                p   = longint'(sa_i) * longint'(sb_i);
                mHI = p[63:32];
                mLO = p[31:0];
                lat = MC;
            end
            4'd9: begin
                p   = {32'h0, a} * {32'h0, b};
                mHI = p[63:32];
                mLO = p[31:0];
                lat = MC;
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            4'd10, 4'd11: begin
                lat = DC;
                if (b == 32'h0) begin
                    mLO = 32'hFFFF_FFFF;
                    mHI = a;
                end else if (op == 4'd11) begin
                    mLO = a / b;
                    mHI = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mLO = a;
                    mHI = 32'h0;
                end else begin
                    mLO = sa_i / sb_i;
                    mHI = sa_i % sb_i;
                end
            end
`endif
            4'd12: mHI = a;
            4'd13: mLO = a;
            default: mC = 32'h0;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int lat;
        int n;
        model(op, a, b, lat);
        ALUOp = op;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ALUOp = 4'($urandom_range(0, 15));
        A     = $urandom;
        B     = $urandom;
        n     = 0;
        while (done !== 1'b1 && n < lat + 4) begin
            chk({tag, ":busy"}, busy, 1);
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ":lat"}, n, lat);
        chk({tag, ":done"}, done, 1);
        chk({tag, ":idle"}, busy, 0);
        chk({tag, ":C"}, C, mC);
        chk({tag, ":HI"}, HI, mHI);
        chk({tag, ":LO"}, LO, mLO);
    endtask

    task automatic quiet(input string tag);
        @(posedge clk);
        #1;
        chk({tag, ":nodone"}, done, 0);
    endtask

    initial begin
        int lat;
        int n;
        int pulses;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        reset = 1'b0;
        start = 1'b0;
        ALUOp = 4'd0;
        A     = '0;
        B     = '0;
        mC    = '0;
        mHI   = '0;
        mLO   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        run_op(4'd0, $urandom, $urandom, "pre_add");
        run_op(4'd12, $urandom, $urandom, "pre_mthi");
        ALUOp = 4'd8;
        A     = $urandom;
        B     = $urandom;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mC  = '0;
        mHI = '0;
        mLO = '0;
        chk("rst:C", C, 0);
        chk("rst:HI", HI, 0);
        chk("rst:LO", LO, 0);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        quiet("rst");

        run_op(4'd1, 32'h3, 32'h5, "sub");
        chk("sub:const", C, 32'hFFFF_FFFE);
        quiet("sub");
        run_op(4'd5, 32'h8000_0000, 32'h24, "sra");
        chk("sra:const", C, 32'hF800_0000);
        run_op(4'd8, 32'hFFFF_FFFF, 32'h2, "mult");
        chk("mult:hi", HI, 32'hFFFF_FFFF);
        chk("mult:lo", LO, 32'hFFFF_FFFE);
        quiet("mult");
        run_op(4'd9, 32'hFFFF_FFFF, 32'h2, "multu");
        chk("multu:hi", HI, 32'h1);
        chk("multu:lo", LO, 32'hFFFF_FFFE);
        run_op(4'd13, 32'h1234_5678, 32'h0, "mtlo");
        run_op(4'd14, 32'h5, 32'h6, "undef");
`ifdef MULTICYCLE_ALU_DIV_EN
        run_op(4'd10, 32'hFFFF_FFF9, 32'h2, "div");
        chk("div:lo", LO, 32'hFFFF_FFFD);
        chk("div:hi", HI, 32'hFFFF_FFFF);
        run_op(4'd10, 32'h5, 32'h0, "div0");
        chk("div0:lo", LO, 32'hFFFF_FFFF);
        chk("div0:hi", HI, 32'h5);
        run_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, "divmin");
        run_op(4'd11, 32'hFFFF_FFF9, 32'h2, "divu");
`else
        run_op(4'd10, 32'h5, 32'h0, "div_off");
        chk("div_off:C", C, 0);
        run_op(4'd11, 32'hFFFF_FFF9, 32'h2, "divu_off");
`endif

        // A start during cycle 2 of a mult must be dropped.
        model(4'd8, 32'h0000_1234, 32'hFFFF_FFF0, lat);
        ALUOp = 4'd8;
        A     = 32'h0000_1234;
        B     = 32'hFFFF_FFF0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        ALUOp = 4'd0;
        A     = 32'h11;
        B     = 32'h22;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 2;
        while (done !== 1'b1 && n < MC + 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ign:lat", n, lat);
        chk("ign:C", C, mC);
        chk("ign:HI", HI, mHI);
        chk("ign:LO", LO, mLO);
        quiet("ign");

        run_op(4'd9, 32'hDEAD_BEEF, 32'h0000_0100, "b2b_mul");
        run_op(4'd0, 32'h7FFF_FFFF, 32'h1, "b2b_add");
        quiet("b2b");

        // Reset during cycle 3 of a multi-cycle op aborts it.
`ifdef MULTICYCLE_ALU_DIV_EN
        op = 4'd10;
`else
        op = 4'd8;
`endif
        ALUOp = op;
        A     = 32'h0000_0064;
        B     = 32'h0000_0007;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mC  = '0;
        mHI = '0;
        mLO = '0;
        chk("abort:busy", busy, 0);
        chk("abort:HI", HI, 0);
        chk("abort:LO", LO, 0);
        chk("abort:C", C, 0);
        pulses = 0;
        for (int i = 0; i < DC + 2; i++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        chk("abort:pulses", pulses, 0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                2: b = 32'($urandom_range(1, 40));
                default: ;
            endcase
            run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
        end
        quiet("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered successor to the single-cycle datapath ALU. It executes the basic logic, arithmetic and shift operations in one cycle. It also executes multiply and divide over a configurable number of cycles, writing HI/LO registers. It sits in the EX stage of the pipelined CPU; the stall unit consumes `busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be a power of two, ≥ 8.
- `MUL_CYCLES`, 5: multiply latency in cycles, ≥ 1.
- `DIV_CYCLES`, 10: divide latency in cycles, ≥ 1.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `start`  in  1: request strobe; accepted only when `busy`=0.
- `ALUOp`  in  4: operation code.
- `A`  in  WIDTH: operand A.
- `B`  in  WIDTH: operand B.
- `C`  out  WIDTH: registered result of the last completed single-cycle op; holds until the next completion.
- `HI`  out  WIDTH: HI register.
- `LO`  out  WIDTH: LO register.
- `busy`  out  1: a multi-cycle op is in flight.
- `done`  out  1: one-cycle pulse when any accepted op completes.

## Operation
- `SA` = `B[log2(WIDTH)-1:0]`.
- Op codes:
  - 0000: A+B.
  - 0001: A−B.
  - 0010: A&B.
  - 0011: A|B.
  - 0100: A>>SA, logical.
  - 0101: A>>>SA, arithmetic.
  - 0110: A<<SA.
  - 0111: signed A<B → 1 else 0.
  - 1000: signed mult.
  - 1001: unsigned multu.
  - 1010: signed div.
  - 1011: unsigned divu.
  - 1100: mthi (HI←A).
  - 1101: mtlo (LO←A).
  - 1110–1111: undefined; C←0.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- Single-cycle ops (0000–0111, 1110, 1111) write `C` only.
- mthi/mtlo write HI/LO only; `C` is unchanged.
- Multiply ops write `{HI,LO}` ← the full 2·WIDTH product and leave `C` unchanged.
- Divide ops write LO ← quotient, truncated toward zero, and HI ← remainder, with the sign of the dividend.
- Divide by zero: LO ← all ones, HI ← A.
- Signed most-negative ÷ −1: LO ← A, HI ← 0.
- Operands and op are latched at accept; input changes while `busy` have no effect.
- States:
  - IDLE → EXEC on an accepted mult/div; any other accepted op stays in IDLE.
  - EXEC counts down from latency−1. At count 0 it writes HI/LO, pulses `done`, and returns to IDLE.
- `start` while `busy`=1 is ignored (no queueing).

## Timing
- Reset (`reset`=0 at an edge) forces: state IDLE, counter 0, C=0, HI=0, LO=0, busy=0, done=0.
- Reset mid-operation aborts the op; HI/LO read 0 afterwards.
- Single-cycle op or mthi/mtlo accepted at edge N: `C`/HI/LO and `done` are visible after edge N; no busy cycle.
- Mult accepted at edge N:
  - `busy`=1 after edges N … N+MUL_CYCLES−1.
  - HI/LO update and `done`=1 after edge N+MUL_CYCLES; `busy`=0 in that same cycle.
  - MUL_CYCLES=1 gives `busy` high for exactly one cycle.
- Div behaves identically with DIV_CYCLES.
- A new `start` is accepted in the same cycle `done` is high, giving back-to-back operation.
- `done` is never high two consecutive cycles for one op.

## Configuration
- `MULTICYCLE_ALU_DIV_EN` defined: div/divu are implemented as specified.
- Undefined: 1010/1011 are treated as undefined ops. They complete in one cycle with C←0, HI/LO unchanged, `busy` never asserted, and no divider logic is synthesised.

## Test plan
- Reset held low 2 cycles after random activity → C=HI=LO=0, busy=done=0.
- Sub, A=0x00000003, B=0x00000005 → C=0xFFFFFFFE one cycle later with a one-cycle `done`. Then sra, A=0x80000000, B=0x00000024 (SA=4) → C=0xF8000000.
- mult, A=0xFFFFFFFF, B=0x00000002 → busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. With the same operands, multu → HI=0x00000001, LO=0xFFFFFFFE.
- div, A=−7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. div, A=5, B=0 → LO=0xFFFFFFFF, HI=0x00000005. With the macro undefined, the same op → C=0, HI/LO unchanged, `done` after 1 cycle.
- Second `start` (add) in cycle 2 of a mult → ignored, no extra `done`. An add issued in the `done` cycle of the mult → accepted; its `done` follows the next cycle.
- `reset` low during cycle 3 of a div → busy=0 and HI=LO=0 the next cycle; no `done` pulse.
